// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the demux_lane_sched controller and its lane registers.
package demux_sched_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;
    localparam int   CNT_W = 8;

    // A lane can take a new word when it is empty or its word leaves this cycle.
    function automatic logic lane_free(input logic valid, input logic drain);
        return !valid || drain;
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// Per-lane output holding register: loads a steered word, drains on consumer ready,
// and holds both valid and data steady while the consumer stalls.
module demux_lane_reg
    import demux_sched_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              drain,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              free
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;

    // Load wins over drain so a word arriving while the old one leaves costs no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
        end else if (drain) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
    assign free  = lane_free(valid_r, drain);

endmodule

// File: rtl/demux_lane_sched.sv
// 1:2 word demux controller: lane pointer, start-up delay, pause/resume and stall flag.
// Optional per-lane handshake counters are built when LANE_STATS_EN is defined.
module demux_lane_sched
    import demux_sched_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int STRICT_ALT  = 1,
    parameter int INIT_CYCLES = 4,
    parameter int STALL_MAX   = 15
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              enable,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_out,
    output logic              valid_out0,
    output logic [DATA_W-1:0] data_out0,
    input  logic              ready_in0,
    output logic              valid_out1,
    output logic [DATA_W-1:0] data_out1,
    input  logic              ready_in1,
    output logic              active_lane,
    output logic              stall_err
`ifdef LANE_STATS_EN
    ,
    output logic [CNT_W-1:0]  cnt_lane0,
    output logic [CNT_W-1:0]  cnt_lane1
`endif
);

    localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);
    localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

    state_e     state_r;
    logic [7:0] init_cnt_r;
    logic       active_lane_r;
    logic [7:0] stall_cnt_r;
    logic       stall_err_r;

    logic free0_s;
    logic free1_s;
    logic free_active_s;
    logic free_other_s;
    logic avail_s;
    logic ready_s;
    logic accept_s;
    logic chosen_s;
    logic load0_s;
    logic load1_s;

    // Intake decision: which lane is usable and whether upstream may transfer.
    always_comb begin
        free_active_s = 1'b0;
        free_other_s  = 1'b0;
        avail_s       = 1'b0;
        chosen_s      = LANE0;
        if (active_lane_r == LANE1) begin
            free_active_s = free1_s;
            free_other_s  = free0_s;
        end else begin
            free_active_s = free0_s;
            free_other_s  = free1_s;
        end
        if (STRICT_ALT != 0) begin
            avail_s = free_active_s;
        end else begin
            avail_s = free_active_s || free_other_s;
        end
        // In strict mode an accept implies the pointed lane is free, so the fallback never fires.
        if (free_active_s) begin
            chosen_s = active_lane_r;
        end else begin
            chosen_s = ~active_lane_r;
        end
    end

    assign ready_s  = (state_r == ST_RUN) && enable && avail_s;
    assign accept_s = valid_in && ready_s;
    assign load0_s  = accept_s && (chosen_s == LANE0);
    assign load1_s  = accept_s && (chosen_s == LANE1);

    // Controller FSM: start-up delay, then run/pause following enable.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_r    <= ST_INIT;
            init_cnt_r <= 8'd0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (init_cnt_r == INIT_LAST) begin
                        state_r    <= ST_RUN;
                        init_cnt_r <= init_cnt_r;
                    end else begin
                        state_r    <= ST_INIT;
                        init_cnt_r <= init_cnt_r + 8'd1;
                    end
                end
                ST_RUN: begin
                    init_cnt_r <= init_cnt_r;
                    if (!enable) begin
                        state_r <= ST_PAUSE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    init_cnt_r <= init_cnt_r;
                    if (enable) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_PAUSE;
                    end
                end
                default: begin
                    state_r    <= ST_INIT;
                    init_cnt_r <= 8'd0;
                end
            endcase
        end
    end

    // Lane pointer moves to the lane opposite the one just loaded.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            active_lane_r <= LANE0;
        end else if (accept_s) begin
            active_lane_r <= ~chosen_s;
        end else begin
            active_lane_r <= active_lane_r;
        end
    end

    // Stall detection: counts consecutive blocked cycles in RUN; the flag is sticky.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            stall_cnt_r <= 8'd0;
            stall_err_r <= 1'b0;
        end else if ((state_r == ST_RUN) && valid_in && !ready_s) begin
            if (stall_cnt_r != STALL_LIM) begin
                stall_cnt_r <= stall_cnt_r + 8'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (stall_cnt_r == (STALL_LIM - 8'd1)) begin
                stall_err_r <= 1'b1;
            end else begin
                stall_err_r <= stall_err_r;
            end
        end else if (!valid_in || accept_s) begin
            stall_cnt_r <= 8'd0;
            stall_err_r <= stall_err_r;
        end else begin
            stall_cnt_r <= stall_cnt_r;
            stall_err_r <= stall_err_r;
        end
    end

    demux_lane_reg #(.DATA_W(DATA_W)) u_lane0 (
        .clk       (clk_4f),
        .reset     (reset),
        .load      (load0_s),
        .load_data (data_in),
        .drain     (ready_in0),
        .valid     (valid_out0),
        .data      (data_out0),
        .free      (free0_s)
    );

    demux_lane_reg #(.DATA_W(DATA_W)) u_lane1 (
        .clk       (clk_4f),
        .reset     (reset),
        .load      (load1_s),
        .load_data (data_in),
        .drain     (ready_in1),
        .valid     (valid_out1),
        .data      (data_out1),
        .free      (free1_s)
    );

`ifdef LANE_STATS_EN
    logic [CNT_W-1:0] cnt_lane0_r;
    logic [CNT_W-1:0] cnt_lane1_r;

    // Handshake counters per lane, wrapping naturally at the counter width.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            cnt_lane0_r <= '0;
            cnt_lane1_r <= '0;
        end else begin
            if (valid_out0 && ready_in0) begin
                cnt_lane0_r <= cnt_lane0_r + CNT_W'(1);
            end else begin
                cnt_lane0_r <= cnt_lane0_r;
            end
            if (valid_out1 && ready_in1) begin
                cnt_lane1_r <= cnt_lane1_r + CNT_W'(1);
            end else begin
                cnt_lane1_r <= cnt_lane1_r;
            end
        end
    end

    assign cnt_lane0 = cnt_lane0_r;
    assign cnt_lane1 = cnt_lane1_r;
`endif

    assign ready_out   = ready_s;
    assign active_lane = active_lane_r;
    assign stall_err   = stall_err_r;

endmodule
